// File: rtl/cpu_axi_bridge_pkg.sv
// Shared types and constants for the SRAM-to-AXI3 bridge: FSM states, AXI IDs,
// burst/size encodings, the latched request record and the write-strobe helper.
package cpu_axi_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_AR,
    ST_R,
    ST_W,
    ST_B
  } state_e;

  localparam logic [3:0] INST_ARID  = 4'd0;
  localparam logic [3:0] DATA_ARID  = 4'd1;
  localparam logic [3:0] WRITE_ID   = 4'd1;

  localparam logic [3:0] LEN_SINGLE = 4'd0;
  localparam logic [1:0] BURST_INCR = 2'b01;

  localparam logic [1:0] SIZE_BYTE  = 2'd0;
  localparam logic [1:0] SIZE_HALF  = 2'd1;
  localparam logic [1:0] SIZE_WORD  = 2'd2;

  typedef struct packed {
    logic        isData;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

  // Lane strobes for a narrow store; the core has already replicated the data lanes.
  function automatic logic [3:0] calcWstrb(input logic [1:0] size, input logic [1:0] offs);
    logic [3:0] strb;
    case (size)
      SIZE_BYTE: strb = 4'b0001 << offs;
      SIZE_HALF: strb = 4'b0011 << {offs[1], 1'b0};
      SIZE_WORD: strb = 4'b1111;
      default:   strb = 4'b0000;
    endcase
    return strb;
  endfunction

endpackage

// File: rtl/cpu_axi_bridge_arbiter.sv
// Grant logic between the inst and data request ports (module bridge_arbiter).
// Define BRIDGE_RR_ARB_EN for round-robin; otherwise data has fixed priority.
module bridge_arbiter
  import cpu_axi_bridge_pkg::*;
(
`ifdef BRIDGE_RR_ARB_EN
  input  logic clk_i,
  input  logic resetn_i,
`endif
  input  logic idle_i,
  input  logic inst_req_i,
  input  logic data_req_i,
  output logic grant_inst_o,
  output logic grant_data_o
);

`ifdef BRIDGE_RR_ARB_EN
  logic last_data_q;

  // On a tie, the port that did not win last time goes first.
  assign grant_data_o = idle_i && data_req_i && (!inst_req_i || !last_data_q);
  assign grant_inst_o = idle_i && inst_req_i && !grant_data_o;

  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      last_data_q <= 1'b0;
    end else if (grant_data_o) begin
      last_data_q <= 1'b1;
    end else if (grant_inst_o) begin
      last_data_q <= 1'b0;
    end
  end
`else
  assign grant_data_o = idle_i && data_req_i;
  assign grant_inst_o = idle_i && inst_req_i && !data_req_i;
`endif

endmodule

// File: rtl/cpu_axi_bridge.sv
// Bridges the core's inst/data SRAM-like ports onto one AXI3 master, one
// transaction in flight. Optional round-robin arbitration via BRIDGE_RR_ARB_EN.
module cpu_axi_bridge
  import cpu_axi_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,

  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,

  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  state_e     state_q;
  req_t       req_q;
  req_t       req_d;
  logic [3:0] wstrb_q;
  logic       arvalid_q;
  logic       rready_q;
  logic       awvalid_q;
  logic       wvalid_q;
  logic       bready_q;

  logic idle;
  logic grantInst;
  logic grantData;
  logic accept;
  logic rDone;
  logic bDone;
  logic awDone;
  logic wDone;
  logic unusedInputs;

  // Reset also blocks new grants so addr_ok stays low while resetn is asserted.
  assign idle = resetn && (state_q == ST_IDLE);

  bridge_arbiter u_arb (
`ifdef BRIDGE_RR_ARB_EN
    .clk_i        (clk),
    .resetn_i     (resetn),
`endif
    .idle_i       (idle),
    .inst_req_i   (inst_req),
    .data_req_i   (data_req),
    .grant_inst_o (grantInst),
    .grant_data_o (grantData)
  );

  assign inst_addr_ok = grantInst;
  assign data_addr_ok = grantData;
  assign accept       = grantInst || grantData;

  always_comb begin
    req_d        = '0;
    req_d.isData = grantData;
    req_d.wr     = grantData && data_wr;
    req_d.size   = grantData ? data_size : inst_size;
    req_d.addr   = grantData ? data_addr : inst_addr;
    req_d.wdata  = data_wdata;
  end

  assign rDone  = resetn && (state_q == ST_R) && rvalid;
  assign bDone  = resetn && (state_q == ST_B) && bvalid;
  assign awDone = !awvalid_q || awready;
  assign wDone  = !wvalid_q || wready;

  assign inst_data_ok = rDone && !req_q.isData;
  assign data_data_ok = (rDone && req_q.isData) || bDone;
  assign inst_rdata   = inst_data_ok ? rdata : 32'd0;
  assign data_rdata   = (rDone && req_q.isData) ? rdata : 32'd0;

  assign arid    = req_q.isData ? DATA_ARID : INST_ARID;
  assign araddr  = req_q.addr;
  assign arsize  = {1'b0, req_q.size};
  assign arvalid = arvalid_q;
  assign rready  = rready_q;

  assign awid    = WRITE_ID;
  assign awaddr  = req_q.addr;
  assign awsize  = {1'b0, req_q.size};
  assign awvalid = awvalid_q;

  assign wid     = WRITE_ID;
  assign wdata   = req_q.wdata;
  assign wstrb   = wstrb_q;
  assign wlast   = 1'b1;
  assign wvalid  = wvalid_q;
  assign bready  = bready_q;

  assign arlen   = LEN_SINGLE;
  assign awlen   = LEN_SINGLE;
  assign arburst = BURST_INCR;
  assign awburst = BURST_INCR;
  assign arlock  = 2'b00;
  assign awlock  = 2'b00;
  assign arcache = 4'b0000;
  assign awcache = 4'b0000;
  assign arprot  = 3'b000;
  assign awprot  = 3'b000;

  // Responses carry no information the core can use, so ids/resps are dropped.
  assign unusedInputs = ^{inst_wr, inst_wdata, rid, rresp, rlast, bid, bresp, req_q.wr};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      req_q     <= '0;
      wstrb_q   <= 4'b0000;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_q <= req_d;
            if (req_d.wr) begin
              state_q   <= ST_W;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              wstrb_q   <= calcWstrb(req_d.size, req_d.addr[1:0]);
            end else begin
              state_q   <= ST_AR;
              arvalid_q <= 1'b1;
            end
          end
        end
        ST_AR: begin
          if (arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_R;
          end
        end
        ST_R: begin
          if (rvalid) begin
            rready_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        // AW and W complete independently; B starts once both are through.
        ST_W: begin
          if (awready) awvalid_q <= 1'b0;
          if (wready)  wvalid_q  <= 1'b0;
          if (awDone && wDone) begin
            bready_q <= 1'b1;
            state_q  <= ST_B;
          end
        end
        ST_B: begin
          if (bvalid) begin
            bready_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_axi_bridge.sv
// Directed bench for cpu_axi_bridge with a response scoreboard; honours BRIDGE_RR_ARB_EN.
module tb_cpu_axi_bridge;

`ifdef BRIDGE_RR_ARB_EN
  localparam bit RR_EN = 1'b1;
`else
  localparam bit RR_EN = 1'b0;
`endif

  logic        clk;
  logic        resetn;
  logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
  logic [1:0]  inst_size;
  logic [31:0] inst_addr, inst_wdata, inst_rdata;
  logic        data_req, data_wr, data_addr_ok, data_data_ok;
  logic [1:0]  data_size;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [3:0]  arid, arlen, arcache, awid, awlen, awcache, wid, wstrb, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [2:0]  arsize, arprot, awsize, awprot;
  logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  typedef struct {
    bit          isData;
    bit          isWrite;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbQueue[$];
  int   compared   = 0;
  int   mismatched = 0;

  cpu_axi_bridge dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_addr(inst_addr),
    .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
    .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok),
    .data_rdata(data_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      $error("[TB] %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit arr, input bit rv, input logic [31:0] rd,
                               input bit awr, input bit wr, input bit bv);
    arready = arr;
    rvalid  = rv;
    rdata   = rd;
    awready = awr;
    wready  = wr;
    bvalid  = bv;
  endtask

  task automatic setInst(input bit req, input logic [31:0] addr, input logic [1:0] size);
    inst_req  = req;
    inst_wr   = 1'b1;
    inst_addr = addr;
    inst_size = size;
  endtask

  task automatic setData(input bit req, input bit wr, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wd);
    data_req   = req;
    data_wr    = wr;
    data_addr  = addr;
    data_size  = size;
    data_wdata = wd;
  endtask

  task automatic push(input bit isData, input bit isWrite, input logic [31:0] rd);
    exp_t e;
    e.isData  = isData;
    e.isWrite = isWrite;
    e.rdata   = rd;
    sbQueue.push_back(e);
  endtask

  // Every data_ok pulse is matched against the oldest expected response.
  always @(negedge clk) begin
    if (inst_data_ok || data_data_ok) begin
      checkOutput("ok_excl", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
      if (sbQueue.size() == 0) begin
        checkOutput("sb_unexpected", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
      end else begin
        exp_t e;
        e = sbQueue.pop_front();
        checkOutput("sb_port", {30'd0, inst_data_ok, data_data_ok}, {30'd0, !e.isData, e.isData});
        if (!e.isWrite)
          checkOutput("sb_rdata", e.isData ? data_rdata : inst_rdata, e.rdata);
      end
    end
  end

  initial begin
    bit          winData;
    logic [31:0] instVal;
    logic [31:0] dataVal;

    rid = 4'd0; rresp = 2'd0; rlast = 1'b1; bid = 4'd0; bresp = 2'd0;
    inst_wdata = 32'h0;
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    resetn = 1'b0;
    setInst(1, 32'h0000_0100, 2'd2);
    setData(1, 1, 32'h0000_0200, 2'd2, 32'hFFFF_FFFF);

    // Reset state, with both ports requesting.
    nextCycle();
    nextCycle();
    sample();
    checkOutput("rst_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    checkOutput("rst_addr_ok", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    checkOutput("rst_data_ok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    checkOutput("rst_araddr", araddr, 32'd0);
    checkOutput("rst_awaddr", awaddr, 32'd0);
    checkOutput("rst_wdata", wdata, 32'd0);
    checkOutput("rst_wstrb", {28'd0, wstrb}, 32'd0);
    checkOutput("rst_rdata", inst_rdata | data_rdata, 32'd0);
    nextCycle();
    resetn = 1'b1;
    setInst(0, 32'h0, 2'd0);
    setData(0, 0, 32'h0, 2'd0, 32'h0);

    // Inst read with a zero-wait slave.
    nextCycle();
    setInst(1, 32'hBFC0_0000, 2'd2);
    sample();
    checkOutput("t1_inst_addr_ok", {31'd0, inst_addr_ok}, 32'd1);
    checkOutput("t1_data_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    checkOutput("t1_arvalid0", {31'd0, arvalid}, 32'd0);
    push(0, 0, 32'h3C08_0001);
    nextCycle();
    setInst(0, 32'h0, 2'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t1_arvalid", {31'd0, arvalid}, 32'd1);
    checkOutput("t1_arid", {28'd0, arid}, 32'd0);
    checkOutput("t1_araddr", araddr, 32'hBFC0_0000);
    checkOutput("t1_arsize", {29'd0, arsize}, 32'd2);
    checkOutput("t1_early_ok", {31'd0, inst_data_ok}, 32'd0);
    nextCycle();
    applyStimulus(0, 1, 32'h3C08_0001, 0, 0, 0);
    sample();
    checkOutput("t1_rready", {31'd0, rready}, 32'd1);
    checkOutput("t1_inst_data_ok", {31'd0, inst_data_ok}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t1_rready_drop", {31'd0, rready}, 32'd0);

    // Simultaneous inst read and data half-word write.
    nextCycle();
    setInst(1, 32'h0000_1000, 2'd2);
    setData(1, 1, 32'h1FAF_0002, 2'd1, 32'hABCD_ABCD);
    sample();
    checkOutput("t2_grant", {30'd0, inst_addr_ok, data_addr_ok}, 32'b01);
    push(1, 1, 32'h0);
    nextCycle();
    setData(0, 0, 32'h0, 2'd0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 0);
    sample();
    checkOutput("t2_aw_w_valid", {30'd0, awvalid, wvalid}, 32'b11);
    checkOutput("t2_wstrb", {28'd0, wstrb}, 32'b1100);
    checkOutput("t2_awsize", {29'd0, awsize}, 32'd1);
    checkOutput("t2_awaddr", awaddr, 32'h1FAF_0002);
    checkOutput("t2_wdata", wdata, 32'hABCD_ABCD);
    checkOutput("t2_inst_wait_w", {31'd0, inst_addr_ok}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("t2_bready", {31'd0, bready}, 32'd1);
    checkOutput("t2_aw_w_drop", {30'd0, awvalid, wvalid}, 32'd0);
    checkOutput("t2_inst_wait_b", {31'd0, inst_addr_ok}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t2_inst_pending", {31'd0, inst_addr_ok}, 32'd1);
    push(0, 0, 32'h1111_2222);
    nextCycle();
    setInst(0, 32'h0, 2'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t2_inst_araddr", araddr, 32'h0000_1000);
    nextCycle();
    applyStimulus(0, 1, 32'h1111_2222, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);

    // Write with AW accepted immediately and W accepted three cycles later.
    nextCycle();
    setData(1, 1, 32'h0000_0010, 2'd2, 32'h1234_5678);
    sample();
    checkOutput("t3_addr_ok", {31'd0, data_addr_ok}, 32'd1);
    push(1, 1, 32'h0);
    nextCycle();
    setData(0, 0, 32'h0, 2'd0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 0, 0);
    sample();
    checkOutput("t3_c1_valids", {30'd0, awvalid, wvalid}, 32'b11);
    checkOutput("t3_wstrb", {28'd0, wstrb}, 32'b1111);
    for (int c = 2; c <= 4; c++) begin
      nextCycle();
      applyStimulus(0, 0, 32'h0, 0, c == 4, 0);
      sample();
      checkOutput($sformatf("t3_c%0d_valids", c), {29'd0, awvalid, wvalid, bready}, 32'b010);
      checkOutput($sformatf("t3_c%0d_dok", c), {31'd0, data_data_ok}, 32'd0);
    end
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t3_c5_valids", {29'd0, awvalid, wvalid, bready}, 32'b001);
    checkOutput("t3_c5_dok", {31'd0, data_data_ok}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("t3_c6_dok", {31'd0, data_data_ok}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);

    // Byte write at offset 3, AW and W handshaking in the same cycle.
    nextCycle();
    setData(1, 1, 32'h2000_0003, 2'd0, 32'h7777_7777);
    sample();
    push(1, 1, 32'h0);
    nextCycle();
    setData(0, 0, 32'h0, 2'd0, 32'h0);
    applyStimulus(0, 0, 32'h0, 1, 1, 0);
    sample();
    checkOutput("t4_wstrb", {28'd0, wstrb}, 32'b1000);
    checkOutput("t4_awsize", {29'd0, awsize}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 1);
    sample();
    checkOutput("t4_bready", {31'd0, bready}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);

    // Tie after a data grant: round-robin favours inst, fixed priority favours data.
    winData = !RR_EN;
    instVal = 32'h1A1A_1A1A;
    dataVal = 32'hD0D0_D0D0;
    nextCycle();
    setInst(1, 32'h0000_2000, 2'd2);
    setData(1, 0, 32'h0000_3000, 2'd2, 32'h0);
    sample();
    checkOutput("t5_grant", {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, !winData, winData});
    push(winData, 0, winData ? dataVal : instVal);
    nextCycle();
    if (winData) data_req = 1'b0;
    else         inst_req = 1'b0;
    applyStimulus(1, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t5_win_arid", {28'd0, arid}, {31'd0, winData});
    checkOutput("t5_win_araddr", araddr, winData ? 32'h0000_3000 : 32'h0000_2000);
    nextCycle();
    applyStimulus(0, 1, winData ? dataVal : instVal, 0, 0, 0);
    sample();
    checkOutput("t5_no_grant_r", {30'd0, inst_addr_ok, data_addr_ok}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t5_loser_grant", {30'd0, inst_addr_ok, data_addr_ok}, {30'd0, winData, !winData});
    push(!winData, 0, winData ? instVal : dataVal);
    nextCycle();
    setInst(0, 32'h0, 2'd0);
    setData(0, 0, 32'h0, 2'd0, 32'h0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t5_lose_arid", {28'd0, arid}, {31'd0, !winData});
    nextCycle();
    applyStimulus(0, 1, winData ? instVal : dataVal, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);

    // Data read with arready delayed 3 cycles and rvalid delayed 2.
    nextCycle();
    setData(1, 0, 32'h4000_0008, 2'd2, 32'h0);
    sample();
    push(1, 0, 32'hCAFE_F00D);
    for (int c = 1; c <= 4; c++) begin
      nextCycle();
      setData(0, 0, 32'h0, 2'd0, 32'h0);
      applyStimulus(c == 4, 0, 32'h0, 0, 0, 0);
      sample();
      checkOutput($sformatf("t6_c%0d_arvalid", c), {31'd0, arvalid}, 32'd1);
      checkOutput($sformatf("t6_c%0d_ar", c), araddr ^ {28'd0, arid}, 32'h4000_0009);
    end
    for (int c = 5; c <= 6; c++) begin
      nextCycle();
      applyStimulus(0, 0, 32'h0, 0, 0, 0);
      sample();
      checkOutput($sformatf("t6_c%0d_rstate", c), {29'd0, arvalid, rready, data_data_ok}, 32'b010);
    end
    nextCycle();
    applyStimulus(0, 1, 32'hCAFE_F00D, 0, 0, 0);
    sample();
    checkOutput("t6_dok", {31'd0, data_data_ok}, 32'd1);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t6_single_pulse", {31'd0, data_data_ok}, 32'd0);

    // Reset while in R, then a stray rvalid, then a clean read.
    nextCycle();
    setInst(1, 32'h0000_0050, 2'd2);
    nextCycle();
    setInst(0, 32'h0, 2'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    resetn = 1'b0;
    sample();
    checkOutput("t7_rst_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    nextCycle();
    resetn = 1'b1;
    applyStimulus(0, 1, 32'hDEAD_BEEF, 0, 0, 0);
    sample();
    checkOutput("t7_valids", {27'd0, arvalid, rready, awvalid, wvalid, bready}, 32'd0);
    checkOutput("t7_no_dok", {30'd0, inst_data_ok, data_data_ok}, 32'd0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    setInst(1, 32'h0000_0060, 2'd2);
    sample();
    checkOutput("t7_new_ok", {31'd0, inst_addr_ok}, 32'd1);
    push(0, 0, 32'h600D_F00D);
    nextCycle();
    setInst(0, 32'h0, 2'd0);
    applyStimulus(1, 0, 32'h0, 0, 0, 0);
    sample();
    checkOutput("t7_araddr", araddr, 32'h0000_0060);
    nextCycle();
    applyStimulus(0, 1, 32'h600D_F00D, 0, 0, 0);
    nextCycle();
    applyStimulus(0, 0, 32'h0, 0, 0, 0);
    sample();

    checkOutput("sb_drained", sbQueue.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
